// File: rtl/idct2d_stream_if.sv
// Valid/ready coefficient-in and pixel-out streams of the 8x8 inverse DCT block.
// The master side drives coefficients and accepts pixels; the slave side is the transform.
interface idct2d_stream_if #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned PIX_W = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [IN_W-1:0]  in_data;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [PIX_W-1:0]        out_data;
   logic                    out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/idct2d_stream.sv
// Streaming 8x8 2-D inverse DCT: the row pass runs while the block loads, then a 64-cycle
// column pass, then 64 level-shifted, clamped pixels are emitted with full backpressure.
module idct2d_stream #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned MID_W = 16,
   parameter int unsigned PIX_W = 8
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   idct2d_stream_if.slave strm,
   output logic           busy,
   output logic           err_len
);
   localparam int unsigned KW   = 16;
   localparam int unsigned OpW  = (IN_W > MID_W) ? IN_W : MID_W;
   localparam int unsigned PrdW = OpW + KW;
   // Eight Q13 products of an OpW operand need OpW + 19 bits to never wrap.
   localparam int unsigned AccW = OpW + 19;

   localparam logic signed [AccW-1:0] Half   = AccW'(64'sd8192);
   localparam logic signed [AccW-1:0] MidMax = AccW'((64'sd1 <<< (MID_W - 1)) - 64'sd1);
   localparam logic signed [AccW-1:0] MidMin = -MidMax - AccW'(64'sd1);
   localparam logic signed [AccW-1:0] PixOff = AccW'(64'sd1 <<< (PIX_W - 1));
   localparam logic signed [AccW-1:0] PixMax = AccW'((64'sd1 <<< PIX_W) - 64'sd1);

   typedef enum logic [1:0] {StLoad, StCol, StOut} state_e;

   // round(8192 * cos(n*pi/16)) for n = 0..8.
   function automatic int cos_q13(input int n);
      case (n)
         0:       return 8192;
         1:       return 8035;
         2:       return 7568;
         3:       return 6811;
         4:       return 5793;
         5:       return 4551;
         6:       return 3135;
         7:       return 1598;
         default: return 0;
      endcase
   endfunction

   function automatic logic signed [KW-1:0] kcoef(input int x, input int u);
      int m;
      int mag;
      if (u == 0) return 16'sd5793;
      m = ((2 * x + 1) * u) % 32;
      if (m > 16) m = 32 - m;
      if (m > 8) mag = -cos_q13(16 - m);
      else       mag = cos_q13(m);
      return KW'(mag);
   endfunction

   function automatic logic signed [MID_W-1:0] sat_mid(input logic signed [AccW-1:0] v);
      if (v > MidMax) return MID_W'(MidMax);
      if (v < MidMin) return MID_W'(MidMin);
      return MID_W'(v);
   endfunction

   function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [AccW-1:0] v);
      logic signed [AccW-1:0] s;
      s = v + PixOff;
      if (s[AccW-1]) return '0;
      if (s > PixMax) return '1;
      return PIX_W'(s);
   endfunction

   state_e                  state_q, state_d;
   logic [5:0]              cnt_q, cnt_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic [PIX_W-1:0]        out_data_q, out_data_d;
   logic                    busy_q, busy_d;
   logic                    err_len_q, err_len_d;
   logic signed [AccW-1:0]  acc_q [8];
   logic signed [AccW-1:0]  acc_d [8];
   logic signed [MID_W-1:0] r_q [8][8];
   logic signed [MID_W-1:0] r_d [8][8];
   logic [PIX_W-1:0]        p_q [8][8];
   logic [PIX_W-1:0]        p_d [8][8];
   logic signed [KW-1:0]    ktab [8][8];
   logic signed [AccW-1:0]  acc_sum [8];
   logic signed [AccW-1:0]  rnd [8];
   logic [2:0]              hi, lo;
   logic                    accept, out_fire, mac_en, col_pass;
   logic signed [OpW-1:0]   op;

   for (genvar gx = 0; gx < 8; gx++) begin : g_krow
      for (genvar gu = 0; gu < 8; gu++) begin : g_kcol
         assign ktab[gx][gu] = kcoef(gx, gu);
      end
   end

   // LOAD: hi = row v, lo = column u. COL: hi = column c, lo = tap v.
   assign hi       = cnt_q[5:3];
   assign lo       = cnt_q[2:0];
   assign col_pass = (state_q == StCol);
   assign accept   = in_ready_q & strm.in_valid;
   assign out_fire = out_valid_q & strm.out_ready;
   assign mac_en   = accept | col_pass;
   assign op       = col_pass ? OpW'(r_q[lo][hi]) : OpW'(strm.in_data);

   always_comb begin
      acc_d = acc_q;
      r_d   = r_q;
      p_d   = p_q;
      for (int x = 0; x < 8; x++) begin
         acc_sum[x] = acc_q[x] + AccW'(PrdW'(op) * PrdW'(ktab[x][lo]));
         rnd[x]     = (acc_sum[x] + Half) >>> 14;
         if (mac_en) acc_d[x] = (lo == 3'd7) ? '0 : acc_sum[x];
         if (accept && lo == 3'd7) r_d[hi][x] = sat_mid(rnd[x]);
         if (col_pass && lo == 3'd7) p_d[x][hi] = clamp_pix(rnd[x]);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StLoad: begin
            if (accept) begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd63) state_d = StCol;
            end
         end
         StCol: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd63) state_d = StOut;
         end
         StOut: begin
            if (out_fire) begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd63) state_d = StLoad;
            end
         end
         default: begin
            state_d = StLoad;
            cnt_d   = '0;
         end
      endcase
      in_ready_d  = (state_d == StLoad);
      out_valid_d = (state_d == StOut);
      busy_d      = (state_d != StLoad);
      out_last_d  = (state_d == StOut) && (cnt_d == 6'd63);
      // Column 0 is long settled when OUT starts, so reading the registered buffer is safe.
      out_data_d  = (state_d == StOut) ? p_q[cnt_d[5:3]][cnt_d[2:0]] : '0;
      err_len_d   = accept & (strm.in_last ^ (cnt_q == 6'd63));
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= StLoad;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         err_len_q   <= 1'b0;
         acc_q       <= '{default: '0};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         err_len_q   <= err_len_d;
         acc_q       <= acc_d;
      end
   end

   // Buffers are only read after being fully written for the current block.
   always_ff @(posedge sys_clk) begin
      r_q <= r_d;
      p_q <= p_d;
   end

   assign strm.in_ready  = in_ready_q;
   assign strm.out_valid = out_valid_q;
   assign strm.out_last  = out_last_q;
   assign strm.out_data  = out_data_q;
   assign busy           = busy_q;
   assign err_len        = err_len_q;
endmodule
